ram_dp_param: RTL and testbench

- Parametrised successor of the team's 4-bit x 8 single-clock RAM.
- Same command encoding on `state`: 0 idle, 1 read, 2 write, 3 simultaneous read+write.
- Adds:
  - generic width and depth;
  - registered read with a valid flag;
  - write-to-read bypass on address collision;
  - a self-clearing init sweep after reset;
  - a busy/error handshake.
- Sits between the FIFO/buffer control logic and storage in the datapath.

---
 rtl/ram_dp_param_pkg.sv | 23 ++
 rtl/ram_dp_param_if.sv | 26 ++
 rtl/ram_init_ctrl.sv | 70 +++++++
 rtl/ram_dp_param.sv | 81 ++++++++
 tb/tb_ram_dp_param.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_dp_param_pkg.sv
// Shared command codes, controller state encoding and command decode helpers
// for the parametrised dual-port RAM.
package ram_dp_param_pkg;

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_RW   = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  function automatic logic cmd_reads(input logic [1:0] cmd);
    return (cmd == CMD_RD) || (cmd == CMD_RW);
  endfunction

  function automatic logic cmd_writes(input logic [1:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RW);
  endfunction

endpackage

// File: rtl/ram_dp_param_if.sv
// Command/data bus between the buffer control logic (master) and the RAM
// (slave).
interface ram_dp_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  logic              enable;
  logic [1:0]        state;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              busy;
  logic              err_out;

  modport master (
    output enable, state, data_in, addr_in, addr_out,
    input  data_out, valid_out, busy, err_out
  );

  modport slave (
    input  enable, state, data_in, addr_in, addr_out,
    output data_out, valid_out, busy, err_out
  );
endinterface

// File: rtl/ram_init_ctrl.sv
// INIT/RUN controller: sweeps INIT_VAL through every entry after reset,
// reports busy, and flags commands that arrive while the sweep is running.
module ram_init_ctrl
  import ram_dp_param_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [1:0]        state,
  output logic              busy,
  output logic              err_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ctrl_state_t       st, st_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              err_q, err_next;

  always_ff @(posedge clk) begin
    if (reset_L) begin
      st    <= ST_INIT;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      st    <= st_next;
      cnt   <= cnt_next;
      err_q <= err_next;
    end
  end

  // The sweep stops at the last entry rather than wrapping back to zero.
  always_comb begin
    st_next  = st;
    cnt_next = cnt;
    err_next = 1'b0;
    busy     = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = cnt;
    wr_data  = INIT_VAL;
    case (st)
      ST_INIT: begin
        busy     = 1'b1;
        wr_en    = 1'b1;
        err_next = enable && (state != CMD_IDLE);
        if (cnt == LAST_ADDR) begin
          st_next = ST_RUN;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b0;
      end
      default: begin
        st_next = ST_INIT;
      end
    endcase
  end

  assign err_out = err_q;

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised single-clock RAM with registered read, write-first bypass on
// address collision and a post-reset initialisation sweep.
module ram_dp_param
  import ram_dp_param_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic           clk,
  input logic           reset_L,
  ram_dp_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        cmd;
  logic              busy, err_out;
  logic              init_wr_en;
  logic [ADDR_W-1:0] init_wr_addr;
  logic [DATA_W-1:0] init_wr_data;
  logic              user_rd, user_wr, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  ram_init_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INIT_VAL(INIT_VAL)
  ) u_init_ctrl (
    .clk    (clk),
    .reset_L(reset_L),
    .enable (bus.enable),
    .state  (bus.state),
    .busy   (busy),
    .err_out(err_out),
    .wr_en  (init_wr_en),
    .wr_addr(init_wr_addr),
    .wr_data(init_wr_data)
  );

  // User commands only reach the array once the sweep is done; the sweep
  // owns the write port while busy.
  always_comb begin
    cmd       = bus.enable ? bus.state : CMD_IDLE;
    user_rd   = !busy && cmd_reads(cmd);
    user_wr   = !busy && cmd_writes(cmd);
    mem_we    = !reset_L && (init_wr_en || user_wr);
    mem_waddr = init_wr_en ? init_wr_addr : bus.addr_in;
    mem_wdata = init_wr_en ? init_wr_data : bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= user_rd;
      if (user_rd) begin
        data_q <= (user_wr && (bus.addr_in == bus.addr_out)) ? bus.data_in
                                                             : mem[bus.addr_out];
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = busy;
  assign bus.err_out   = err_out;

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: directed vector table, a mid-run reset sequence and
// a randomized run checked against an array-based reference model.
module tb_ram_dp_param;

  localparam int              DATA_W   = 4;
  localparam int              ADDR_W   = 3;
  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] INIT_VAL = '0;

  typedef struct {
    logic              rst;
    logic              en;
    logic [1:0]        st;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] ain;
    logic [ADDR_W-1:0] aout;
    logic [DATA_W-1:0] exp_dout;
    logic              exp_valid;
    logic              exp_busy;
    logic              exp_err;
  } vec_t;

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  vec_t vecs[$];

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_dout;
  logic              m_valid;
  logic              m_err;
  int                m_busy_left;

  ram_dp_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_dp_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INIT_VAL(INIT_VAL)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one clock edge, stated in terms of the command
  // rules: reset restarts a DEPTH-cycle sweep, commands during it are
  // dropped and flagged, afterwards reads/writes act on a plain array.
  task automatic model_edge(input logic rst, input logic en, input logic [1:0] st,
                            input logic [DATA_W-1:0] din,
                            input logic [ADDR_W-1:0] ain, input logic [ADDR_W-1:0] aout);
    logic rd, wr;
    if (rst) begin
      m_busy_left = DEPTH;
      m_dout      = '0;
      m_valid     = 1'b0;
      m_err       = 1'b0;
    end else if (m_busy_left > 0) begin
      m_err = en && (st != 2'd0);
      m_mem[DEPTH - m_busy_left] = INIT_VAL;
      m_busy_left = m_busy_left - 1;
      m_valid = 1'b0;
    end else begin
      rd = en && (st == 2'd1 || st == 2'd3);
      wr = en && (st == 2'd2 || st == 2'd3);
      m_err   = 1'b0;
      m_valid = rd;
      if (rd) m_dout = (wr && ain == aout) ? din : m_mem[aout];
      if (wr) m_mem[ain] = din;
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic en, input logic [1:0] st,
                                input logic [DATA_W-1:0] din,
                                input logic [ADDR_W-1:0] ain, input logic [ADDR_W-1:0] aout);
    reset_L      = rst;
    bus.enable   = en;
    bus.state    = st;
    bus.data_in  = din;
    bus.addr_in  = ain;
    bus.addr_out = aout;
    @(posedge clk);
    model_edge(rst, en, st, din, ain, aout);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_against_model(input string tag);
    check_output({tag, ".data_out"},  int'(bus.data_out),  int'(m_dout));
    check_output({tag, ".valid_out"}, int'(bus.valid_out), int'(m_valid));
    check_output({tag, ".busy"},      int'(bus.busy),      int'(m_busy_left > 0));
    check_output({tag, ".err_out"},   int'(bus.err_out),   int'(m_err));
  endtask

  function automatic void add_vec(input logic rst, input logic en, input logic [1:0] st,
                                  input int din, input int ain, input int aout,
                                  input int ed, input logic ev, input logic eb,
                                  input logic ee);
    vec_t v;
    v.rst       = rst;
    v.en        = en;
    v.st        = st;
    v.din       = DATA_W'(din);
    v.ain       = ADDR_W'(ain);
    v.aout      = ADDR_W'(aout);
    v.exp_dout  = DATA_W'(ed);
    v.exp_valid = ev;
    v.exp_busy  = eb;
    v.exp_err   = ee;
    vecs.push_back(v);
  endfunction

  initial begin
    int busy_cycles;
    checks  = 0;
    errors  = 0;
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    reset_L      = 1'b1;
    bus.enable   = 1'b0;
    bus.state    = 2'd0;
    bus.data_in  = '0;
    bus.addr_in  = '0;
    bus.addr_out = '0;

    // Directed table: reset, sweep with a dropped write, read-back, write and
    // read sweeps, collision bypass and enable gating.
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= DEPTH; k++)
      add_vec(0, k == 3, (k == 3) ? 2'd2 : 2'd0, (k == 3) ? 'hA : 0, 3, 0,
              0, 0, k < DEPTH, k == 3);
    for (int a = 0; a < DEPTH; a++) add_vec(0, 1, 1, 0, 0, a, 0, 1, 0, 0);
    for (int k = 1; k <= DEPTH; k++) add_vec(0, 1, 2, k, k % DEPTH, 0, 0, 0, 0, 0);
    for (int k = 1; k <= DEPTH; k++) add_vec(0, 1, 1, 0, 0, k % DEPTH, k, 1, 0, 0);
    add_vec(0, 1, 2, 3, 5, 0, 8, 0, 0, 0);
    add_vec(0, 1, 2, 2, 4, 0, 8, 0, 0, 0);
    add_vec(0, 1, 3, 9, 5, 5, 9, 1, 0, 0);
    add_vec(0, 1, 3, 'hC, 6, 4, 2, 1, 0, 0);
    add_vec(0, 1, 1, 0, 0, 5, 9, 1, 0, 0);
    add_vec(0, 1, 1, 0, 0, 6, 'hC, 1, 0, 0);
    add_vec(0, 0, 2, 'hF, 1, 0, 'hC, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, 2, 'hC, 0, 0, 0);
    add_vec(0, 1, 0, 7, 1, 1, 'hC, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 1, 1, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].din,
                     vecs[i].ain, vecs[i].aout);
      check_output($sformatf("vec%0d.data_out", i),  int'(bus.data_out),  int'(vecs[i].exp_dout));
      check_output($sformatf("vec%0d.valid_out", i), int'(bus.valid_out), int'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d.busy", i),      int'(bus.busy),      int'(vecs[i].exp_busy));
      check_output($sformatf("vec%0d.err_out", i),   int'(bus.err_out),   int'(vecs[i].exp_err));
    end

    // Mid-run reset during a read stream, then count the busy window and
    // confirm the sweep cleared every entry.
    apply_stimulus(0, 1, 1, 0, 0, 2);
    check_against_model("midrst_read2");
    apply_stimulus(1, 1, 1, 0, 0, 3);
    check_against_model("midrst_reset");
    busy_cycles = int'(bus.busy);
    for (int k = 0; k < DEPTH + 2; k++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_against_model($sformatf("midrst_sweep%0d", k));
      if (bus.busy) busy_cycles++;
    end
    check_output("midrst_busy_cycles", busy_cycles, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      apply_stimulus(0, 1, 1, 0, 0, ADDR_W'(a));
      check_output($sformatf("midrst_clear%0d", a), int'(bus.data_out), int'(INIT_VAL));
    end

    // Randomized traffic with occasional resets, checked against the model.
    for (int n = 0; n < 800; n++) begin
      apply_stimulus($urandom_range(0, 99) == 0,
                     $urandom_range(0, 3) != 0,
                     2'($urandom_range(0, 3)),
                     DATA_W'($urandom),
                     ADDR_W'($urandom),
                     ADDR_W'($urandom));
      check_against_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
